// File: rtl/mul_seq_param_if.sv
// mul_seq_param_if: operand/product handshake bundle (in_valid/in_ready/x_in/y_in/signed_in, out_valid/out_ready/product)
interface mul_seq_param_if #(
  parameter int X_W = 16,
  parameter int Y_W = 9
);
  logic               in_valid;
  logic               in_ready;
  logic [X_W-1:0]     x_in;
  logic [Y_W-1:0]     y_in;
  logic               signed_in;
  logic               out_valid;
  logic               out_ready;
  logic [X_W+Y_W-1:0] product;
  modport slave (
    input  in_valid, x_in, y_in, signed_in, out_ready,
    output in_ready, out_valid, product
  );
  modport master (
    output in_valid, x_in, y_in, signed_in, out_ready,
    input  in_ready, out_valid, product
  );
endinterface

// File: rtl/mul_seq_param.sv
// mul_seq_param: shift-add multiplier retiring R multiplier bits per cycle; ports clk, rst_n (sync, active-low), bus (slave handshake)
module mul_seq_param #(
  parameter int X_W = 16,
  parameter int Y_W = 9,
  parameter int R   = 1
) (
  input logic            clk,
  input logic            rst_n,
  mul_seq_param_if.slave bus
);
  localparam int N   = (Y_W + R - 1) / R;
  localparam int P_W = X_W + Y_W;
  localparam int YP  = N * R;
  localparam int CW  = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t         st, nx;
  logic [P_W-1:0] xs, acc, acc_n, part, prod_q;
  logic [YP-1:0]  ys;
  logic [CW-1:0]  cnt;
  logic           neg, last, x_neg, y_neg;
  logic [X_W-1:0] x_mag;
  logic [Y_W-1:0] y_mag;
  always_comb begin
    x_neg = bus.signed_in & bus.x_in[X_W-1];
    y_neg = bus.signed_in & bus.y_in[Y_W-1];
    x_mag = x_neg ? -bus.x_in : bus.x_in;
    y_mag = y_neg ? -bus.y_in : bus.y_in;
    part  = xs * P_W'(ys[R-1:0]);
    acc_n = acc + part;
    last  = cnt == CW'(N - 1);
    nx    = st == IDLE ? (bus.in_valid ? BUSY : IDLE) :
            st == BUSY ? (last ? DONE : BUSY) :
            st == DONE ? (bus.out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_n) st <= IDLE;
    else        st <= nx;
  // Multiplicand shifts left and multiplier shifts right so each cycle uses only the low chunk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xs     <= '0;
      ys     <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      prod_q <= '0;
    end else if (st == IDLE && bus.in_valid) begin
      xs  <= P_W'(x_mag);
      ys  <= YP'(y_mag);
      acc <= '0;
      cnt <= '0;
      neg <= x_neg ^ y_neg;
    end else if (st == BUSY) begin
      xs  <= xs << R;
      ys  <= ys >> R;
      acc <= acc_n;
      cnt <= cnt + CW'(1);
      if (last) prod_q <= neg ? -acc_n : acc_n;
    end
  end
  assign bus.in_ready  = rst_n & (st == IDLE);
  assign bus.out_valid = st == DONE;
  assign bus.product   = prod_q;
endmodule

// File: tb/tb_mul_seq_param.sv
// tb_mul_seq_param: randomized and directed checks of R=1 and R=2 builds against an arithmetic reference
module tb_mul_seq_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  logic        iv[2], ors[2], sg[2], ir[2], ov[2];
  logic [15:0] xi[2];
  logic [8:0]  yi[2];
  logic [24:0] pr[2];
  mul_seq_param_if #(.X_W(16), .Y_W(9)) ia ();
  mul_seq_param_if #(.X_W(16), .Y_W(9)) ib ();
  mul_seq_param #(.X_W(16), .Y_W(9), .R(1)) ua (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  mul_seq_param #(.X_W(16), .Y_W(9), .R(2)) ub (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  assign ia.in_valid = iv[0];
  assign ia.x_in = xi[0];
  assign ia.y_in = yi[0];
  assign ia.signed_in = sg[0];
  assign ia.out_ready = ors[0];
  assign ib.in_valid = iv[1];
  assign ib.x_in = xi[1];
  assign ib.y_in = yi[1];
  assign ib.signed_in = sg[1];
  assign ib.out_ready = ors[1];
  assign ir[0] = ia.in_ready;
  assign ov[0] = ia.out_valid;
  assign pr[0] = ia.product;
  assign ir[1] = ib.in_ready;
  assign ov[1] = ib.out_valid;
  assign pr[1] = ib.product;

  function automatic logic [24:0] ref_mul(input logic [15:0] x, input logic [8:0] y, input logic s);
    longint a, b;
    a = s ? longint'($signed(x)) : longint'(x);
    b = s ? longint'($signed(y)) : longint'(y);
    return 25'(a * b);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int w, input logic [15:0] x, input logic [8:0] y, input logic s,
                        output logic [24:0] p, output int lat);
    int t = 0;
    while (!ir[w] && t < 50) begin step(); t++; end
    iv[w] = 1'b1; xi[w] = x; yi[w] = y; sg[w] = s;
    step();
    iv[w] = 1'b0; xi[w] = 16'($urandom); yi[w] = 9'($urandom); sg[w] = 1'($urandom);
    lat = 0;
    while (!ov[w] && lat < 100) begin step(); lat++; end
    p = pr[w];
    ors[w] = 1'b1;
    step();
    ors[w] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    for (int w = 0; w < 2; w++) begin
      n_cmp++;
      if (ir[w] !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready_low[%0d] got=%b exp=0", w, ir[w]); end
    end
    rst_n = 1'b1;
    #1;
    for (int w = 0; w < 2; w++) begin
      n_cmp += 3;
      if (ir[w] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready[%0d] got=%b exp=1", w, ir[w]); end
      if (ov[w] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid[%0d] got=%b exp=0", w, ov[w]); end
      if (pr[w] !== 25'd0) begin n_bad++; $display("FAIL reset_product[%0d] got=%0h exp=0", w, pr[w]); end
    end
  endtask

  task automatic test_directed();
    logic [15:0] tx[6] = '{16'hAAAA, 16'd256, 16'd24618, 16'd8000, 16'hFFFD, 16'h8000};
    logic [8:0]  ty[6] = '{9'h16B, 9'd100, 9'd500, 9'd300, 9'd5, 9'h100};
    logic        ts[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [24:0] te[6] = '{25'd15859470, 25'd25600, 25'd12309000, 25'd2400000, 25'h1FFFFF1, 25'h0800000};
    int          tl[2] = '{9, 5};
    logic [24:0] p;
    int lat;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 6; i++) begin
        run_op(w, tx[i], ty[i], ts[i], p, lat);
        n_cmp += 2;
        if (p !== te[i]) begin n_bad++; $display("FAIL directed_product[%0d][%0d] got=%0h exp=%0h", w, i, p, te[i]); end
        if (lat != tl[w]) begin n_bad++; $display("FAIL directed_latency[%0d][%0d] got=%0d exp=%0d", w, i, lat, tl[w]); end
      end
  endtask

  task automatic test_backpressure();
    logic [24:0] e = ref_mul(16'h1234, 9'h0AB, 1'b0);
    int t = 0;
    iv[0] = 1'b1; xi[0] = 16'h1234; yi[0] = 9'h0AB; sg[0] = 1'b0;
    step();
    iv[0] = 1'b0;
    while (!ov[0] && t < 100) begin step(); t++; end
    n_cmp++;
    if (ov[0] !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid_timeout got=%b exp=1", ov[0]); end
    for (int i = 0; i < 20; i++) begin
      n_cmp += 3;
      if (pr[0] !== e) begin n_bad++; $display("FAIL bp_product_stable[%0d] got=%0h exp=%0h", i, pr[0], e); end
      if (ir[0] !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, ir[0]); end
      if (ov[0] !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, ov[0]); end
      iv[0] = i == 10; xi[0] = 16'hFFFF; yi[0] = 9'h1FF;
      step();
    end
    iv[0] = 1'b0;
    ors[0] = 1'b1;
    step();
    ors[0] = 1'b0;
    n_cmp += 3;
    if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL bp_after_handshake_valid got=%b exp=0", ov[0]); end
    if (ir[0] !== 1'b1) begin n_bad++; $display("FAIL bp_after_handshake_ready got=%b exp=1", ir[0]); end
    if (pr[0] !== e) begin n_bad++; $display("FAIL bp_after_handshake_product got=%0h exp=%0h", pr[0], e); end
  endtask

  task automatic test_reset_mid();
    logic [24:0] p;
    int lat;
    iv[0] = 1'b1; xi[0] = 16'h7777; yi[0] = 9'h155; sg[0] = 1'b0;
    step();
    iv[0] = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    n_cmp += 2;
    if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid got=%b exp=0", ov[0]); end
    if (pr[0] !== 25'd0) begin n_bad++; $display("FAIL mid_reset_product got=%0h exp=0", pr[0]); end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (ir[0] !== 1'b1) begin n_bad++; $display("FAIL mid_reset_idle got=%b exp=1", ir[0]); end
    for (int i = 0; i < 15; i++) begin
      step();
      n_cmp++;
      if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL mid_reset_no_valid[%0d] got=%b exp=0", i, ov[0]); end
    end
    run_op(0, 16'h0123, 9'h045, 1'b0, p, lat);
    n_cmp++;
    if (p !== ref_mul(16'h0123, 9'h045, 1'b0)) begin n_bad++; $display("FAIL mid_reset_next_op got=%0h exp=%0h", p, ref_mul(16'h0123, 9'h045, 1'b0)); end
  endtask

  task automatic test_random();
    logic [15:0] x;
    logic [8:0]  y;
    logic        s;
    logic [24:0] p;
    int lat;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < (w == 1 ? 500 : 150); i++) begin
        x = 16'($urandom); y = 9'($urandom); s = 1'($urandom);
        case ($urandom_range(0, 7))
          0: x = 16'h8000;
          1: y = 9'h100;
          2: x = 16'd0;
          3: y = 9'h1FF;
          default: ;
        endcase
        run_op(w, x, y, s, p, lat);
        n_cmp++;
        if (p !== ref_mul(x, y, s)) begin n_bad++; $display("FAIL random[%0d][%0d] x=%0h y=%0h s=%b got=%0h exp=%0h", w, i, x, y, s, p, ref_mul(x, y, s)); end
      end
  endtask

  task automatic test_back_to_back();
    logic [24:0] q[$];
    int cyc = 0, last = -1, got = 0, n_acc = 0;
    bit acc_now;
    ors[0] = 1'b1;
    iv[0] = 1'b1; xi[0] = 16'($urandom); yi[0] = 9'($urandom); sg[0] = 1'($urandom);
    while ((n_acc < 6 || q.size() != 0) && cyc < 200) begin
      acc_now = 1'b0;
      if (ov[0]) begin
        n_cmp++;
        if (q.size() == 0) begin n_bad++; $display("FAIL b2b_unexpected_product got=%0h exp=none", pr[0]); end
        else if (pr[0] !== q[0]) begin n_bad++; $display("FAIL b2b_product[%0d] got=%0h exp=%0h", got, pr[0], q[0]); end
        if (q.size() != 0) void'(q.pop_front());
        got++;
      end
      if (ir[0] && iv[0]) begin
        q.push_back(ref_mul(xi[0], yi[0], sg[0]));
        if (last >= 0) begin
          n_cmp++;
          if (cyc - last != 11) begin n_bad++; $display("FAIL b2b_interval got=%0d exp=11", cyc - last); end
        end
        last = cyc;
        n_acc++;
        acc_now = 1'b1;
      end
      step();
      cyc++;
      if (acc_now) begin
        xi[0] = 16'($urandom); yi[0] = 9'($urandom); sg[0] = 1'($urandom);
        if (n_acc >= 6) iv[0] = 1'b0;
      end
    end
    iv[0] = 1'b0;
    ors[0] = 1'b0;
    n_cmp++;
    if (got != 6) begin n_bad++; $display("FAIL b2b_count got=%0d exp=6", got); end
  endtask

  initial begin
    for (int w = 0; w < 2; w++) begin
      iv[w] = 1'b0; ors[w] = 1'b0; sg[w] = 1'b0; xi[w] = '0; yi[w] = '0;
    end
    #1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
